ppu_chr_arbiter: RTL and testbench

// - Owns the single CHR-RAM SRAM port and shares it between PPU pattern fetches and CPU $2007 (cfg) accesses.
// - Cfg accesses only use slots the PPU leaves free, so renders no longer glitch when the CPU touches PT space.
// - Sits between the PPU fetch pipeline / $2007 logic and the external 16-bit SRAM pins.

---
 rtl/ppu_chr_pkg.sv | 34 +++
 rtl/ppu_toggle_sync.sv | 34 +++
 rtl/ppu_chr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ppu_chr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_chr_pkg.sv
// ppu_chr_pkg
//   Shared definitions for the CHR-RAM arbiter: FSM state encoding, SRAM
//   idle-level constants, and the mapping from a CPU-side cfg byte address
//   onto the 16-bit SRAM word address and byte-lane enables.
//   Optional feature macro used by the top: PPU_CHR_ARB_STATS_EN.
package ppu_chr_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_CFG  = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  // Levels the SRAM control pins sit at whenever nobody owns the bus.
  localparam logic SRAM_WE_N_IDLE = 1'b1;
  localparam logic SRAM_OE_N_IDLE = 1'b0;
  localparam logic SRAM_UB_N_IDLE = 1'b0;
  localparam logic SRAM_LB_N_IDLE = 1'b0;

  typedef struct packed {
    logic [11:0] addr;
    logic        ub_n;
    logic        lb_n;
  } cfg_map_t;

  // Bit 3 of the byte address picks the lane; the remaining bits form the word address.
  function automatic cfg_map_t cfg_map(input logic [12:0] byte_addr);
    cfg_map_t m;
    m.addr = {byte_addr[12:4], byte_addr[2:0]};
    m.ub_n = ~byte_addr[3];
    m.lb_n = byte_addr[3];
    return m;
  endfunction

endpackage

// File: rtl/ppu_toggle_sync.sv
// ppu_toggle_sync
//   Two-flop synchronizer for a toggle-encoded request from another clock
//   domain, followed by an edge detector that pulses for one cycle per toggle.
//   Ports:
//     ppu_clk   in  clock
//     ppu_rstn  in  async active-low reset
//     tgl       in  asynchronous toggle input
//     tgl_edge  out one-cycle pulse per toggle edge
module ppu_toggle_sync (
  input  logic ppu_clk,
  input  logic ppu_rstn,
  input  logic tgl,
  output logic tgl_edge
);

  logic sync1;
  logic sync2;
  logic last_seen;

  always_ff @(posedge ppu_clk or negedge ppu_rstn) begin
    if (!ppu_rstn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      sync1     <= tgl;
      sync2     <= sync1;
      last_seen <= sync2;
    end
  end

  assign tgl_edge = sync2 ^ last_seen;

endmodule

// File: rtl/ppu_chr_arbiter.sv
// ppu_chr_arbiter
//   Owns the single CHR-RAM SRAM port and shares it between PPU pattern
//   fetches (fixed 2-cycle latency, back-to-back capable) and CPU $2007 cfg
//   accesses, which are slotted into cycles the PPU leaves free. A cfg
//   request that waits STARVE_LIMIT cycles forces a slot and the colliding
//   PPU request is refused via o_pt_drop.
//   Ports:
//     i_ppu_clk / i_ppu_rstn            clock, async active-low reset
//     i_pt_req / i_pt_addr              PPU fetch request
//     o_pt_rdata / o_pt_rvalid          PPU fetch data, valid 2 cycles after request
//     o_pt_drop                         PPU request refused this cycle
//     i_cfg_req_tgl, i_cfg_addr,
//     i_cfg_we, i_cfg_wdata             CPU-domain toggle request and its operands
//     o_cfg_ack_tgl / o_cfg_rdata       completion toggle and read byte
//     o_sram_*  / i_sram_rdata          registered SRAM pins
//     o_drop_cnt                        saturating drop counter (PPU_CHR_ARB_STATS_EN only)
//   Config macro: PPU_CHR_ARB_STATS_EN adds o_drop_cnt.
//
//   state  | meaning
//   S_IDLE | no cfg request outstanding
//   S_PEND | cfg request waiting for a free bus slot
//   S_CFG  | bus carries the cfg access this cycle
//   S_ACK  | capture read byte, toggle ack, release request
module ppu_chr_arbiter
  import ppu_chr_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        i_ppu_clk,
  input  logic        i_ppu_rstn,
  input  logic        i_pt_req,
  input  logic [11:0] i_pt_addr,
  output logic [15:0] o_pt_rdata,
  output logic        o_pt_rvalid,
  output logic        o_pt_drop,
  input  logic        i_cfg_req_tgl,
  input  logic [12:0] i_cfg_addr,
  input  logic        i_cfg_we,
  input  logic [7:0]  i_cfg_wdata,
  output logic        o_cfg_ack_tgl,
  output logic [7:0]  o_cfg_rdata,
  output logic [11:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
`ifdef PPU_CHR_ARB_STATS_EN
  ,
  output logic [15:0] o_drop_cnt
`endif
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             req_pend;
  logic             req_edge;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             cfg_grant;
  logic             pt_serve;
  logic             pt_on_bus;
  logic [7:0]       cfg_sample;
  cfg_map_t         cmap;

  ppu_toggle_sync u_req_sync (
    .ppu_clk  (i_ppu_clk),
    .ppu_rstn (i_ppu_rstn),
    .tgl      (i_cfg_req_tgl),
    .tgl_edge (req_edge)
  );

  assign cmap = cfg_map(i_cfg_addr);

  assign starved   = (state == S_PEND) && i_pt_req && (starve_cnt == CNT_W'(STARVE_LIMIT - 1));
  assign cfg_grant = (state == S_PEND) && (!i_pt_req || starved);
  // The S_CFG cycle is reserved: a PPU request then would collide in the
  // pipeline with the cfg completion, so it is refused rather than queued.
  assign pt_serve  = i_pt_req && (state != S_CFG) && !cfg_grant;
  assign o_pt_drop = i_pt_req && !pt_serve;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_pend) state_nxt = S_PEND;
      S_PEND: if (cfg_grant) state_nxt = S_CFG;
      S_CFG:  state_nxt = S_ACK;
      S_ACK:  state_nxt = req_edge ? S_PEND : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      state      <= S_IDLE;
      req_pend   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Edges arriving while a request is outstanding are dropped; the ack
      // cycle frees the slot so an edge seen there starts the next request.
      if (state == S_ACK) begin
        req_pend <= req_edge;
      end else if (req_edge && !req_pend) begin
        req_pend <= 1'b1;
      end
      if (state == S_ACK) begin
        starve_cnt <= '0;
      end else if ((state == S_PEND) && i_pt_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_we_n  <= SRAM_WE_N_IDLE;
      o_sram_oe_n  <= SRAM_OE_N_IDLE;
      o_sram_ub_n  <= SRAM_UB_N_IDLE;
      o_sram_lb_n  <= SRAM_LB_N_IDLE;
    end else if (cfg_grant) begin
      o_sram_addr  <= cmap.addr;
      o_sram_ub_n  <= cmap.ub_n;
      o_sram_lb_n  <= cmap.lb_n;
      o_sram_we_n  <= ~i_cfg_we;
      o_sram_oe_n  <= i_cfg_we;
      if (!i_cfg_we) begin
        o_sram_wdata <= '0;
      end else if (i_cfg_addr[3]) begin
        o_sram_wdata <= {i_cfg_wdata, 8'h00};
      end else begin
        o_sram_wdata <= {8'h00, i_cfg_wdata};
      end
    end else begin
      if (pt_serve) o_sram_addr <= i_pt_addr;
      o_sram_wdata <= '0;
      o_sram_we_n  <= SRAM_WE_N_IDLE;
      o_sram_oe_n  <= SRAM_OE_N_IDLE;
      o_sram_ub_n  <= SRAM_UB_N_IDLE;
      o_sram_lb_n  <= SRAM_LB_N_IDLE;
    end
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      pt_on_bus   <= 1'b0;
      o_pt_rvalid <= 1'b0;
      o_pt_rdata  <= '0;
    end else begin
      pt_on_bus   <= pt_serve;
      o_pt_rvalid <= pt_on_bus;
      if (pt_on_bus) o_pt_rdata <= i_sram_rdata;
    end
  end

  // Read data is sampled at the end of the S_CFG bus cycle and published
  // together with the ack toggle so the CPU side sees both change at once.
  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      cfg_sample    <= '0;
      o_cfg_rdata   <= '0;
      o_cfg_ack_tgl <= 1'b0;
    end else begin
      if (state == S_CFG) begin
        cfg_sample <= i_cfg_addr[3] ? i_sram_rdata[15:8] : i_sram_rdata[7:0];
      end
      if (state == S_ACK) begin
        o_cfg_ack_tgl <= ~o_cfg_ack_tgl;
        if (!i_cfg_we) o_cfg_rdata <= cfg_sample;
      end
    end
  end

`ifdef PPU_CHR_ARB_STATS_EN
  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      o_drop_cnt <= '0;
    end else if (o_pt_drop && (o_drop_cnt != 16'hFFFF)) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ppu_chr_arbiter.sv
// tb_ppu_chr_arbiter
//   Directed bench for ppu_chr_arbiter with an SRAM model and a PPU-read
//   scoreboard. Honours PPU_CHR_ARB_STATS_EN when defined.
module tb_ppu_chr_arbiter;
  import ppu_chr_pkg::*;

  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pt_req;
  logic [11:0] pt_addr;
  logic [15:0] pt_rdata;
  logic        pt_rvalid;
  logic        pt_drop;
  logic        cfg_tgl;
  logic [12:0] cfg_addr;
  logic        cfg_we;
  logic [7:0]  cfg_wdata;
  logic        ack_tgl;
  logic [7:0]  cfg_rdata;
  logic [11:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
`ifdef PPU_CHR_ARB_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic exp_ack = 1'b0;
  int exp_drops = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] mem [0:4095];

  logic [11:0] snap_addr;
  logic [15:0] snap_wdata;
  logic        snap_ub_n;
  logic        snap_lb_n;
  logic        snap_oe_n;

  ppu_chr_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .i_ppu_clk     (clk),
    .i_ppu_rstn    (rstn),
    .i_pt_req      (pt_req),
    .i_pt_addr     (pt_addr),
    .o_pt_rdata    (pt_rdata),
    .o_pt_rvalid   (pt_rvalid),
    .o_pt_drop     (pt_drop),
    .i_cfg_req_tgl (cfg_tgl),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_we      (cfg_we),
    .i_cfg_wdata   (cfg_wdata),
    .o_cfg_ack_tgl (ack_tgl),
    .o_cfg_rdata   (cfg_rdata),
    .o_sram_addr   (sram_addr),
    .o_sram_wdata  (sram_wdata),
    .i_sram_rdata  (sram_rdata),
    .o_sram_we_n   (sram_we_n),
    .o_sram_oe_n   (sram_oe_n),
    .o_sram_ub_n   (sram_ub_n),
    .o_sram_lb_n   (sram_lb_n)
`ifdef PPU_CHR_ARB_STATS_EN
    ,
    .o_drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: asynchronous read, byte-lane write at the clock edge.
  assign sram_rdata = mem[sram_addr];

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4096; i++) begin
        mem[i] <= 16'(i) ^ 16'h9000;
      end
      mem[12'h123] <= 16'hA55A;
      mem[12'h005] <= 16'h00E7;
    end else if (!sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_wdata[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_wdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted PPU requests are queued with their issue cycle;
  // every rvalid must match the oldest entry exactly two cycles later.
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
    end else begin
      if (pt_req && !pt_drop) sbq.push_back('{data: mem[pt_addr], cyc: cyc});
      if (pt_rvalid) begin
        chk("rvalid_expected", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("pt_rdata", 32'(pt_rdata), 32'(e.data));
          chk("pt_latency", 32'(cyc), 32'(e.cyc + 2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: no PPU traffic, 1: PPU requests on odd cycles, 2: PPU held until a drop
  task automatic cfg_access(input logic [12:0] a, input logic we, input logic [7:0] wd,
                            input int mode, output int we_cyc, output int drop_n,
                            output int drop_k, output logic [7:0] rd, output bit done);
    bit released;
    released = 0;
    we_cyc = 0;
    drop_n = 0;
    drop_k = -1;
    rd = '0;
    done = 0;
    exp_ack = ~exp_ack;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (k == 0) begin
        cfg_addr  = a;
        cfg_we    = we;
        cfg_wdata = wd;
        cfg_tgl   = ~cfg_tgl;
      end
      case (mode)
        0:       pt_req = 1'b0;
        1:       pt_req = k[0];
        default: pt_req = !released;
      endcase
      pt_addr = 12'h200 + 12'(k);
      @(negedge clk);
      if (!sram_we_n) begin
        we_cyc++;
        snap_addr  = sram_addr;
        snap_wdata = sram_wdata;
        snap_ub_n  = sram_ub_n;
        snap_lb_n  = sram_lb_n;
        snap_oe_n  = sram_oe_n;
      end
      if (pt_drop) begin
        drop_n++;
        if (drop_k < 0) drop_k = k;
        released = 1;
      end
      if (ack_tgl === exp_ack) begin
        done = 1;
        rd = cfg_rdata;
      end
    end
    tick();
    pt_req = 1'b0;
  endtask

  initial begin
    int we_cyc, drop_n, drop_k, we_low;
    logic [7:0] rd;
    bit done, hit;

    rstn = 1'b0;
    pt_req = 1'b0;
    pt_addr = '0;
    cfg_tgl = 1'b0;
    cfg_addr = '0;
    cfg_we = 1'b0;
    cfg_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd0);
    chk("rst_rvalid", 32'(pt_rvalid), 32'd0);
    chk("rst_ack", 32'(ack_tgl), 32'd0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("post_rst_addr", 32'(sram_addr), 32'h0);
    chk("post_rst_ack", 32'(ack_tgl), 32'd0);
    chk("post_rst_rvalid", 32'(pt_rvalid), 32'd0);

    // Single PPU read
    tick();
    pt_req = 1'b1;
    pt_addr = 12'h123;
    @(negedge clk);
    chk("ppu_drop", 32'(pt_drop), 32'd0);
    tick();
    pt_req = 1'b0;
    @(negedge clk);
    chk("ppu_bus_addr", 32'(sram_addr), 32'h123);
    chk("ppu_bus_oe_n", 32'(sram_oe_n), 32'd0);
    chk("ppu_bus_we_n", 32'(sram_we_n), 32'd1);
    tick();
    @(negedge clk);
    chk("ppu_rvalid", 32'(pt_rvalid), 32'd1);
    chk("ppu_rdata", 32'(pt_rdata), 32'hA55A);

    // Back-to-back PPU reads
    for (int i = 0; i < 6; i++) begin
      tick();
      pt_req = 1'b1;
      pt_addr = 12'h010 + 12'(i);
    end
    tick();
    pt_req = 1'b0;
    repeat (4) tick();

    // Cfg write into a free slot: byte 0x3C into upper lane of word 0
    cfg_access(13'h0008, 1'b1, 8'h3C, 0, we_cyc, drop_n, drop_k, rd, done);
    chk("wr_ack", 32'(done), 32'd1);
    chk("wr_we_cycles", 32'(we_cyc), 32'd1);
    chk("wr_addr", 32'(snap_addr), 32'h000);
    chk("wr_ub_n", 32'(snap_ub_n), 32'd0);
    chk("wr_lb_n", 32'(snap_lb_n), 32'd1);
    chk("wr_wdata", 32'(snap_wdata), 32'h3C00);
    chk("wr_oe_n", 32'(snap_oe_n), 32'd1);
    chk("wr_drops", 32'(drop_n), 32'd0);

    // Cfg read interleaved with PPU traffic; the PPU request falling in the
    // S_CFG cycle is the only one refused.
    cfg_access(13'h0005, 1'b0, 8'h00, 1, we_cyc, drop_n, drop_k, rd, done);
    exp_drops += 1;
    chk("rd_ack", 32'(done), 32'd1);
    chk("rd_data", 32'(rd), 32'hE7);
    chk("rd_we_cycles", 32'(we_cyc), 32'd0);
    chk("rd_drops", 32'(drop_n), 32'd1);

    // Starvation: PPU holds the bus; grant forced in the STARVE_LIMIT-th S_PEND cycle.
    // Toggle -> 2 sync cycles -> req_pend -> S_PEND, so S_PEND starts 4 cycles after the toggle.
    cfg_access(13'h0008, 1'b0, 8'h00, 2, we_cyc, drop_n, drop_k, rd, done);
    exp_drops += 1;
    chk("starve_ack", 32'(done), 32'd1);
    chk("starve_drops", 32'(drop_n), 32'd1);
    chk("starve_drop_cycle", 32'(drop_k), 32'(4 + STARVE_LIMIT - 1));
    chk("starve_rdata", 32'(rd), 32'h3C);
`ifdef PPU_CHR_ARB_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif

    repeat (6) tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    // Reset in the middle of a cfg write
    tick();
    cfg_addr = 13'h0010;
    cfg_we = 1'b1;
    cfg_wdata = 8'h55;
    cfg_tgl = ~cfg_tgl;
    pt_req = 1'b0;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (!sram_we_n) hit = 1;
      else tick();
    end
    chk("mid_rst_reached_cfg", 32'(hit), 32'd1);
    #2;
    rstn = 1'b0;
    cfg_tgl = 1'b0;
    exp_ack = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_oe_n", 32'(sram_oe_n), 32'd0);
    chk("mid_rst_addr", 32'(sram_addr), 32'h0);
    repeat (2) tick();
    rstn = 1'b1;
    we_low = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!sram_we_n) we_low++;
      tick();
    end
    chk("mid_rst_no_ack", 32'(ack_tgl), 32'(exp_ack));
    chk("mid_rst_no_write", 32'(we_low), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(S_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
